// File: rtl/ps2_key_tracker.sv
// PS/2 key-event front end.
// Pops scan-code bytes from the ps2_keyboard receiver and parses E0/F0 prefixes.
// Tracks the held key, counts distinct presses and flags typematic repeats.
// Drives hex seven-segment digits from the tracked state.
//
// Receiver handshake: ps2_ready high means ps2_data holds a valid FIFO head.
// In a cycle where ps2_ready=1 and the fetch FSM is idle, ps2_nextdata_n is
// driven low. That cycle both consumes ps2_data and pops the FIFO. A one-cycle
// gap always follows, so the receiver sees its new head before the next pop.
module ps2_key_tracker #(
  parameter int NUM_DIGITS     = 6,
  parameter int CNT_W          = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              ps2_data,
  input  logic                    ps2_ready,
  input  logic                    ps2_overflow,
  output logic                    ps2_nextdata_n,
  output logic [7:0]              o_key_code,
  output logic                    o_key_ext,
  output logic                    o_key_valid,
  output logic [CNT_W-1:0]        o_press_cnt,
  output logic                    o_repeat,
  output logic                    o_err,
  output logic [8*NUM_DIGITS-1:0] o_seg,
  output logic                    dbg_fetch_state,
  output logic [1:0]              dbg_parse_state
);

  typedef enum logic {F_IDLE, F_GAP} fetch_t;
  typedef enum logic [1:0] {P_BASE, P_E0, P_F0, P_E0F0} parse_t;

  localparam int PAD_W = 4*NUM_DIGITS + CNT_W;

  fetch_t     f_state, f_next;
  parse_t     p_state, p_next;
  logic       pop;
  logic       is_ctrl;
  logic       make_ev, brk_ev, ev_ext;
  logic       same_key;

  assign dbg_fetch_state = f_state;
  assign dbg_parse_state = p_state;
  assign ps2_nextdata_n  = ~pop;

  // Fetch next-state: pop only from idle, and never while reset is held.
  always_comb begin
    f_next = f_state;
    pop    = 1'b0;
    case (f_state)
      F_IDLE: begin
        if (ps2_ready && !rst) begin
          pop    = 1'b1;
          f_next = F_GAP;
        end
      end
      F_GAP:   f_next = F_IDLE;
      default: f_next = F_IDLE;
    endcase
  end

  // Fetch state register.
  always_ff @(posedge clk) begin
    if (rst) f_state <= F_IDLE;
    else     f_state <= f_next;
  end

  // Receiver control bytes never reach the key parser.
  always_comb begin
    case (ps2_data)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF, 8'hE1: is_ctrl = 1'b1;
      default:                                               is_ctrl = 1'b0;
    endcase
  end

  // Parse next-state and make/break event decode; overflow discards any prefix.
  always_comb begin
    p_next  = p_state;
    make_ev = 1'b0;
    brk_ev  = 1'b0;
    ev_ext  = 1'b0;
    if (ps2_overflow) begin
      p_next = P_BASE;
    end else if (pop) begin
      if (is_ctrl) begin
        p_next = P_BASE;
      end else begin
        case (p_state)
          P_BASE: begin
            if (ps2_data == 8'hE0)      p_next = P_E0;
            else if (ps2_data == 8'hF0) p_next = P_F0;
            else                        make_ev = 1'b1;
          end
          P_E0: begin
            if (ps2_data == 8'hF0)      p_next = P_E0F0;
            else if (ps2_data == 8'hE0) p_next = P_E0;
            else begin
              make_ev = 1'b1;
              ev_ext  = 1'b1;
              p_next  = P_BASE;
            end
          end
          P_F0: begin
            brk_ev = 1'b1;
            p_next = P_BASE;
          end
          P_E0F0: begin
            brk_ev = 1'b1;
            ev_ext = 1'b1;
            p_next = P_BASE;
          end
          default: p_next = P_BASE;
        endcase
      end
    end
  end

  // Parse state register.
  always_ff @(posedge clk) begin
    if (rst) p_state <= P_BASE;
    else     p_state <= p_next;
  end

  assign same_key = o_key_valid && (o_key_ext == ev_ext) && (o_key_code == ps2_data);

  // Held-key tracking, press counting and repeat pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_key_code  <= 8'h00;
      o_key_ext   <= 1'b0;
      o_key_valid <= 1'b0;
      o_press_cnt <= '0;
      o_repeat    <= 1'b0;
    end else begin
      o_repeat <= 1'b0;
      if (make_ev) begin
        if (same_key) begin
          o_repeat <= 1'b1;
        end else begin
          o_key_code  <= ps2_data;
          o_key_ext   <= ev_ext;
          o_key_valid <= 1'b1;
          o_press_cnt <= o_press_cnt + CNT_W'(1);
        end
      end else if (brk_ev && same_key) begin
        o_key_valid <= 1'b0;
      end
    end
  end

  // Sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst)               o_err <= 1'b0;
    else if (ps2_overflow) o_err <= 1'b1;
  end

  function automatic logic [7:0] seg_glyph(input logic [3:0] nib, input logic dp);
    logic [6:0] font;
    case (nib)
      4'h0: font = 7'h3F;  4'h1: font = 7'h06;  4'h2: font = 7'h5B;  4'h3: font = 7'h4F;
      4'h4: font = 7'h66;  4'h5: font = 7'h6D;  4'h6: font = 7'h7D;  4'h7: font = 7'h07;
      4'h8: font = 7'h7F;  4'h9: font = 7'h6F;  4'hA: font = 7'h77;  4'hB: font = 7'h7C;
      4'hC: font = 7'h39;  4'hD: font = 7'h5E;  4'hE: font = 7'h79;  default: font = 7'h71;
    endcase
    return SEG_ACTIVE_LOW ? ~{dp, font} : {dp, font};
  endfunction

  function automatic logic [8*NUM_DIGITS-1:0] build_seg(input logic valid, input logic ext,
                                                         input logic [7:0] code,
                                                         input logic [CNT_W-1:0] cnt);
    logic [8*NUM_DIGITS-1:0] s;
    logic [PAD_W-1:0]        pad;
    logic [7:0]              blank;
    blank = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    pad   = PAD_W'(cnt);
    s     = '0;
    s[7:0]  = valid ? seg_glyph(code[3:0], ext)  : blank;
    s[15:8] = valid ? seg_glyph(code[7:4], 1'b0) : blank;
    for (int i = 2; i < NUM_DIGITS; i++) begin
      s[8*i +: 8] = seg_glyph(pad[4*(i-2) +: 4], 1'b0);
    end
    return s;
  endfunction

  // Display register, one cycle behind the key state.
  always_ff @(posedge clk) begin
    if (rst) o_seg <= build_seg(1'b0, 1'b0, 8'h00, '0);
    else     o_seg <= build_seg(o_key_valid, o_key_ext, o_key_code, o_press_cnt);
  end

endmodule
